// File: rtl/run_ctrl.sv
// run_ctrl: program loader and run supervisor for the single-cycle core.
// Streams machine words into the instruction memory write port while the
// core is held in reset, then releases the core, pulses its start request
// and watches for completion or a cycle-limit timeout.
module run_ctrl #(
  parameter int D       = 10,
  parameter int W       = 9,
  parameter int CW      = 16,
  parameter int MAX_CYC = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld_valid,
  input  logic [W-1:0]  ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          im_wr_en,
  output logic [D-1:0]  im_wr_addr,
  output logic [W-1:0]  im_wr_data,
  input  logic          start,
  output logic          cpu_rst,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic          busy,
  output logic          fin,
  output logic          timeout,
  output logic [CW-1:0] cyc_cnt,
  output logic [D:0]    prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_RST,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  // Word count at which the memory is full; the load ends there even
  // without ld_last so the pointer never wraps onto address 0.
  localparam logic [D:0]    FULL_CNT  = {1'b1, {D{1'b0}}};
  localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYC);

  state_t        state;
  state_t        state_nxt;
  logic [D:0]    wr_ptr;
  logic [D:0]    wr_ptr_nxt;
  logic          rst_cnt;
  logic [CW-1:0] cyc_q;
  logic [CW-1:0] cyc_inc;
  logic [D:0]    len_q;
  logic          accept;
  logic          end_load;
  logic          enter_rst;

  logic          vld_p1;
  logic [D-1:0]  addr_p1;
  logic [W-1:0]  data_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-state and status decode; clr overrides every other event
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    cpu_req   = 1'b0;
    busy      = 1'b0;
    fin       = 1'b0;
    timeout   = 1'b0;

    case (state)
      S_IDLE:  ld_ready = reset;
      S_LOAD: begin
        ld_ready = reset;
        busy     = 1'b1;
      end
      S_ARMED: ;
      S_RST:   busy = 1'b1;
      S_RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
        // The counter is cleared on entry to RST, so zero marks the first RUN cycle.
        cpu_req = (cyc_q == '0);
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        fin     = 1'b1;
      end
      S_TOUT: begin
        cpu_rst = 1'b0;
        timeout = 1'b1;
      end
      default: ;
    endcase

    accept     = ld_valid && ld_ready && !clr;
    wr_ptr_nxt = wr_ptr + 1'b1;
    end_load   = accept && (ld_last || (wr_ptr_nxt == FULL_CNT));
    cyc_inc    = sat_inc(cyc_q);

    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = end_load ? S_ARMED : S_LOAD;
        S_LOAD:  if (end_load) state_nxt = S_ARMED;
        S_ARMED,
        S_DONE,
        S_TOUT:  if (start) state_nxt = S_RST;
        S_RST:   if (rst_cnt) state_nxt = S_RUN;
        S_RUN: begin
          if (cpu_done)                  state_nxt = S_DONE;
          else if (cyc_inc == CYC_LIMIT) state_nxt = S_TOUT;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    enter_rst = (state != S_RST) && (state_nxt == S_RST);
  end

  // FSM state register; rst_cnt marks the second RST cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rst_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= (state == S_RST);
    end
  end

  // Load pointer, program length and run-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      len_q  <= '0;
      cyc_q  <= '0;
    end else if (clr) begin
      // The cycle count of the last run stays visible after clr.
      wr_ptr <= '0;
      len_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr_nxt;
        if (end_load)
          len_q <= wr_ptr_nxt;
        else if (state == S_IDLE)
          len_q <= '0;
      end
      if (enter_rst)
        cyc_q <= '0;
      else if (state == S_RUN)
        cyc_q <= cyc_inc;
    end
  end

  // Stage p1: registered instruction-memory write of the accepted word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= wr_ptr[D-1:0];
        data_p1 <= ld_data;
      end
    end
  end

  assign im_wr_en   = vld_p1;
  assign im_wr_addr = addr_p1;
  assign im_wr_data = data_p1;
  assign cyc_cnt    = cyc_q;
  assign prog_len   = len_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: small address space (D=3) and a short cycle limit
// (MAX_CYC=100) so load overflow and timeout are reachable quickly.
// Expected memory writes and run results are queued as stimulus is driven
// and compared when the design produces them.
module tb_run_ctrl;

  localparam int D       = 3;
  localparam int W       = 9;
  localparam int CW      = 16;
  localparam int MAX_CYC = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          ld_valid;
  logic [W-1:0]  ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          im_wr_en;
  logic [D-1:0]  im_wr_addr;
  logic [W-1:0]  im_wr_data;
  logic          start;
  logic          cpu_rst;
  logic          cpu_req;
  logic          cpu_done;
  logic          busy;
  logic          fin;
  logic          timeout;
  logic [CW-1:0] cyc_cnt;
  logic [D:0]    prog_len;

  run_ctrl #(.D(D), .W(W), .CW(CW), .MAX_CYC(MAX_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .im_wr_data (im_wr_data),
    .start      (start),
    .cpu_rst    (cpu_rst),
    .cpu_req    (cpu_req),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .fin        (fin),
    .timeout    (timeout),
    .cyc_cnt    (cyc_cnt),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    int fin;
    int tout;
    int cnt;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_chk   = 0;
  int   n_err   = 0;
  int   cyc_no  = 0;
  int   req_cnt = 0;
  logic end_seen = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Memory-write and run-result monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (im_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(im_wr_addr), e.addr);
        chk("wr_data", 32'(im_wr_data), e.data);
        chk("wr_cycle", cyc_no, e.cyc);
      end
    end
    if (cpu_req === 1'b1) req_cnt++;
    if ((fin === 1'b1 || timeout === 1'b1) && !end_seen) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("res_fin", 32'(fin), r.fin);
        chk("res_tout", 32'(timeout), r.tout);
        chk("res_cyc", 32'(cyc_cnt), r.cnt);
      end
    end
    end_seen <= (fin === 1'b1 || timeout === 1'b1);
  end

  // Drive n words; the first n_acc are expected to be accepted and written
  task automatic load_prog(input int n, input int base, input bit use_last, input int n_acc);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = W'(base + i);
      ld_last  = use_last && (i == n - 1);
      if (i < n_acc) begin
        chk("ld_ready", 32'(ld_ready), 1);
        wr_q.push_back('{addr: i, data: base + i, cyc: cyc_no + 1});
        tick();
      end else begin
        chk("ld_stall_a", 32'(ld_ready), 0);
        tick();
        chk("ld_stall_b", 32'(ld_ready), 0);
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
  endtask

  // Start from ARMED/DONE/TOUT; core reports done on RUN cycle done_k (0 = never)
  task automatic run_prog(input int done_k, input int exp_cnt, input bit exp_tout);
    int r0;
    r0 = req_cnt;
    res_q.push_back('{fin: exp_tout ? 0 : 1, tout: exp_tout ? 1 : 0, cnt: exp_cnt});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_hold1", 32'(cpu_rst), 1);
    chk("fin_clr", 32'(fin), 0);
    chk("tout_clr", 32'(timeout), 0);
    chk("busy_rst", 32'(busy), 1);
    tick();
    chk("rst_hold2", 32'(cpu_rst), 1);
    chk("req_early", 32'(cpu_req), 0);
    tick();
    chk("rst_release", 32'(cpu_rst), 0);
    chk("req_first", 32'(cpu_req), 1);
    for (int k = 1; k <= exp_cnt; k++) begin
      cpu_done = (k == done_k);
      if (k == 2) chk("req_once", 32'(cpu_req), 0);
      if (k == exp_cnt) chk("busy_run", 32'(busy), 1);
      tick();
    end
    cpu_done = 1'b0;
    chk("end_fin", 32'(fin), exp_tout ? 0 : 1);
    chk("end_tout", 32'(timeout), exp_tout ? 1 : 0);
    chk("end_cyc", 32'(cyc_cnt), exp_cnt);
    chk("end_busy", 32'(busy), 0);
    chk("end_cpu_rst", 32'(cpu_rst), 0);
    tick();
    chk("req_pulses", req_cnt - r0, 1);
    chk("res_drained", res_q.size(), 0);
  endtask

  initial begin
    int r0;
    reset    = 1'b0;
    clr      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    start    = 1'b0;
    cpu_done = 1'b0;
    tick();
    tick();

    // Values held while reset is asserted
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fin", 32'(fin), 0);
    chk("rst_tout", 32'(timeout), 0);
    chk("rst_req", 32'(cpu_req), 0);
    chk("rst_wr_en", 32'(im_wr_en), 0);
    chk("rst_cyc", 32'(cyc_cnt), 0);
    chk("rst_len", 32'(prog_len), 0);
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(ld_ready), 1);

    // Five-word program with ld_last on the fifth word
    load_prog(5, 'h1A0, 1'b1, 5);
    chk("armed_len", 32'(prog_len), 5);
    chk("armed_ready", 32'(ld_ready), 0);
    chk("armed_cpu_rst", 32'(cpu_rst), 1);
    chk("armed_busy", 32'(busy), 0);
    tick();
    chk("wr_drained1", wr_q.size(), 0);

    // Normal run, rerun without reload, then timeout
    run_prog(37, 37, 1'b0);
    run_prog(12, 12, 1'b0);
    chk("rerun_len", 32'(prog_len), 5);
    run_prog(0, MAX_CYC, 1'b1);

    // clr from TOUT: back to IDLE, length dropped, cycle count kept
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ready", 32'(ld_ready), 1);
    chk("clr_len", 32'(prog_len), 0);
    chk("clr_cyc_hold", 32'(cyc_cnt), MAX_CYC);
    chk("clr_tout", 32'(timeout), 0);
    chk("clr_cpu_rst", 32'(cpu_rst), 1);

    // start while IDLE is ignored
    r0 = req_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_start_ready", 32'(ld_ready), 1);
    chk("idle_start_busy", 32'(busy), 0);
    chk("idle_start_rst", 32'(cpu_rst), 1);
    chk("idle_start_req", req_cnt - r0, 0);

    // Overflow: ten words without ld_last into an 8-entry memory
    load_prog(10, 'h0F0, 1'b0, 8);
    chk("ovf_len", 32'(prog_len), 8);
    chk("ovf_ready", 32'(ld_ready), 0);
    chk("ovf_cpu_rst", 32'(cpu_rst), 1);
    chk("ovf_busy", 32'(busy), 0);
    tick();
    chk("wr_drained2", wr_q.size(), 0);

    // clr together with start in ARMED: clr wins, no run starts
    r0 = req_cnt;
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    chk("clrst_ready", 32'(ld_ready), 1);
    chk("clrst_len", 32'(prog_len), 0);
    chk("clrst_cpu_rst", 32'(cpu_rst), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("clrst_busy", 32'(busy), 0);
    chk("clrst_req", req_cnt - r0, 0);

    // Reload, start, and assert reset on RUN cycle 20
    load_prog(5, 'h1A0, 1'b1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_run_req", 32'(cpu_req), 1);
    for (int k = 1; k < 20; k++) tick();
    chk("mid_run_cyc", 32'(cyc_cnt), 19);
    chk("mid_run_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async_cpu_rst", 32'(cpu_rst), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_cyc", 32'(cyc_cnt), 0);
    chk("async_len", 32'(prog_len), 0);
    chk("async_ready", 32'(ld_ready), 0);
    chk("async_req", 32'(cpu_req), 0);
    chk("async_fin", 32'(fin), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ld_ready), 1);
    chk("wr_drained3", wr_q.size(), 0);
    chk("res_drained_end", res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Bound on total runtime so the bench always terminates
  initial begin
    #200000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Upstream harness stage for the single-cycle core.
- Accepts a stream of 9-bit machine words through a valid/ready load port and writes them into the instruction memory write port.
- Holds the core in reset while loading, then releases it and issues the core's req start pulse.
- Waits for the core's done, counting cycles and enforcing a timeout, and reports status to the host.

Parameters:
- D, 10: instruction address width (matches program counter width).
- W, 9: machine code width.
- CW, 16: cycle counter width.
- MAX_CYC, 4000: run-cycle limit; reaching it ends the run as a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous return to IDLE; discards the loaded program length.
- ld_valid  in  1  load word valid.
- ld_data  in  W  load machine word.
- ld_last  in  1  marks the final word of the program.
- ld_ready  out  1  load port ready.
- im_wr_en  out  1  instruction memory write enable.
- im_wr_addr  out  D  instruction memory write address.
- im_wr_data  out  W  instruction memory write data.
- start  in  1  host request to run the loaded program.
- cpu_rst  out  1  active-high reset to the core.
- cpu_req  out  1  one-cycle start pulse to the core.
- cpu_done  in  1  core completion flag.
- busy  out  1  high in LOAD, RST and RUN.
- fin  out  1  run completed normally.
- timeout  out  1  run hit MAX_CYC.
- cyc_cnt  out  CW  run cycle count.
- prog_len  out  D+1  number of words loaded.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - cpu_rst = 1; every other output = 0; cyc_cnt = 0; prog_len = 0.
- States: IDLE, LOAD, ARMED, RST, RUN, DONE, TOUT.
- Load handshake:
  - ld_ready = 1 only in IDLE and LOAD.
  - A word is accepted when ld_valid && ld_ready.
- Memory writes:
  - Registered: one cycle after acceptance, im_wr_en = 1 with im_wr_addr = write pointer and im_wr_data = accepted word.
  - The write pointer starts at 0 and increments per accepted word.
- IDLE -> LOAD on the first accepted word; that word is written to address 0, and prog_len = 0 is cleared on entry.
- LOAD -> ARMED on an accepted word with ld_last = 1; prog_len = total words accepted.
- Overflow:
  - Acceptance of the 2^D-th word forces the LOAD -> ARMED transition regardless of ld_last.
  - prog_len = 2^D; the pointer never wraps and no further words are accepted.
- cpu_rst = 1 in IDLE, LOAD, ARMED and RST; 0 in RUN, DONE and TOUT. The core stays idle in DONE/TOUT because cpu_req is not re-pulsed.
- ARMED -> RST on start. A start in IDLE or LOAD is ignored.
- RST lasts exactly 2 cycles, then -> RUN. cyc_cnt is cleared on entry to RST.
- RUN:
  - cpu_req = 1 on the first RUN cycle only.
  - cyc_cnt increments every RUN cycle, starting at 1 on the first cycle.
  - If cpu_done = 1 -> DONE; cyc_cnt freezes at the value of that cycle, including that cycle.
  - Else if cyc_cnt reaches MAX_CYC -> TOUT.
  - cpu_done on the req cycle counts as completion.
- cpu_done is ignored in every state other than RUN.
- fin = 1 only in DONE; timeout = 1 only in TOUT.
- From DONE or TOUT:
  - start -> RST: reruns the same program without reloading, and clears fin/timeout on the RST transition.
  - ld_valid is not accepted.
- clr in any state -> IDLE next cycle; prog_len = 0; cyc_cnt holds its value.
- Simultaneous events:
  - clr has priority over start and load acceptance.
  - In RUN, cpu_done has priority over timeout on the same cycle.
- Reset asserted mid-run or mid-load: immediate return to reset values. Partially written memory contents are not cleared.
- cyc_cnt saturates at 2^CW-1. MAX_CYC must be below this value.

Test Plan:
- Load 5 words 0x1A0..0x1A4, last on the 5th:
  - im_wr addresses 0..4 each written one cycle after acceptance.
  - prog_len = 5; state ARMED; ld_ready = 0; cpu_rst = 1.
- ARMED, start pulse, core raises cpu_done on its 37th RUN cycle:
  - cpu_rst low 3 cycles after start; single cpu_req pulse.
  - fin = 1; cyc_cnt = 37; busy = 0.
- cpu_done never asserted, MAX_CYC = 100: timeout = 1 after 100 RUN cycles; cyc_cnt = 100; fin = 0.
- D = 3, stream 10 words with ld_last low:
  - Exactly 8 writes, to addresses 0..7; prog_len = 8; ARMED after the 8th acceptance.
  - Words 9 and 10 are stalled (ld_ready = 0).
- DONE, then start, then cpu_done after 12 cycles:
  - No reload occurs; fin drops during RST.
  - fin = 1; cyc_cnt = 12.
- reset low mid-RUN (cycle 20), and clr asserted together with start in ARMED:
  - Async reset returns outputs to reset values in the same cycle.
  - clr+start leads to IDLE with no cpu_req.
